// File: rtl/player_overlay_renderer.sv
// player_overlay_renderer: N-player pixel compositor feeding the VGA driver.
// Player geometry is latched once per frame. Each pixel then takes two
// registered stages: a per-player hit test, then a priority colour select.
// A per-player hit-flash inverts that player's body colour for a set number
// of frames.
// Optional feature macro: HITBOX_OVERLAY_EN. When defined, hit and hurt box
// borders are drawn over the bodies. When undefined, only bodies and the
// background are drawn, and the box inputs are ignored.
module player_overlay_renderer #(
  parameter int          NUM_PLAYERS  = 2,
  parameter int          COORD_W      = 10,
  parameter int          BOX_W        = 100,
  parameter int          BOX_H        = 100,
  parameter int          FLASH_FRAMES = 8,
  parameter logic [7:0]  BG_COLOR     = 8'b00100101
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_tick,
  input  logic                             pix_valid,
  input  logic [COORD_W-1:0]               pix_x,
  input  logic [COORD_W-1:0]               pix_y,
  input  logic [NUM_PLAYERS*COORD_W-1:0]   posx_flat,
  input  logic [NUM_PLAYERS*COORD_W-1:0]   posy_flat,
  input  logic [NUM_PLAYERS*4-1:0]         state_flat,
  input  logic [NUM_PLAYERS*4*COORD_W-1:0] hit_box_flat,
  input  logic [NUM_PLAYERS*4*COORD_W-1:0] hurt_box_flat,
  input  logic [NUM_PLAYERS-1:0]           hit_pulse,
  output logic [7:0]                       color_out,
  output logic                             color_valid,
  output logic [NUM_PLAYERS-1:0]           flash_active
);

  localparam logic [7:0]       RED    = 8'b11100000;
  localparam logic [7:0]       YELLOW = 8'b11111100;
  localparam logic [COORD_W:0] LP_BW  = (COORD_W+1)'(BOX_W);
  localparam logic [COORD_W:0] LP_BH  = (COORD_W+1)'(BOX_H);
  localparam logic [7:0]       LP_FF  = 8'(FLASH_FRAMES);

  // The extent sums are one bit wider than a coordinate, so a body near the
  // screen limit is clipped there and never wraps back to small coordinates.
  function automatic logic f_in_body(input logic [COORD_W-1:0] px, py, x, y);
    logic [COORD_W:0] xe, ye;
    xe = {1'b0, px} + LP_BW;
    ye = {1'b0, py} + LP_BH;
    return (x >= px) && ({1'b0, x} < xe) && (y >= py) && ({1'b0, y} < ye);
  endfunction

  function automatic logic [7:0] f_body_color(input logic [3:0] st);
    case (st)
      4'd0:    return 8'b11100000;
      4'd1:    return 8'b00001111;
      4'd2:    return 8'b11110000;
      4'd3:    return 8'b00011111;
      4'd4:    return 8'b11111100;
      default: return 8'b11111111;
    endcase
  endfunction

  // Reload on a hit. Otherwise count down once per frame and stop at zero.
  function automatic logic [7:0] f_flash_next(input logic [7:0] cnt, input logic load, tick);
    if (load)
      return LP_FF;
    else if (tick && (cnt != 8'd0))
      return cnt - 8'd1;
    else
      return cnt;
  endfunction

  logic [COORD_W-1:0] r_px [NUM_PLAYERS];
  logic [COORD_W-1:0] r_py [NUM_PLAYERS];
  logic [3:0]         r_st [NUM_PLAYERS];
  logic               r_loaded;
  logic [7:0]         r_flash_cnt [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] r_flash_active;

  logic               r_vld_p1;
  logic               r_loaded_p1;
  logic [NUM_PLAYERS-1:0] r_body_p1;
  logic [NUM_PLAYERS-1:0] r_inv_p1;
  logic [3:0]         r_state_p1 [NUM_PLAYERS];

  logic [NUM_PLAYERS-1:0] w_body;
  logic [7:0]         w_color;

`ifdef HITBOX_OVERLAY_EN
  // A box {x1,x2,y1,y2} with x1 > x2 or y1 > y2 is treated as empty.
  function automatic logic f_on_border(input logic [4*COORD_W-1:0] b, input logic [COORD_W-1:0] x, y);
    logic [COORD_W-1:0] x1, x2, y1, y2;
    x1 = b[3*COORD_W +: COORD_W];
    x2 = b[2*COORD_W +: COORD_W];
    y1 = b[COORD_W +: COORD_W];
    y2 = b[0 +: COORD_W];
    if ((x1 > x2) || (y1 > y2))
      return 1'b0;
    return (((x == x1) || (x == x2)) && (y >= y1) && (y <= y2)) ||
           (((y == y1) || (y == y2)) && (x >= x1) && (x <= x2));
  endfunction

  logic [4*COORD_W-1:0] r_hit  [NUM_PLAYERS];
  logic [4*COORD_W-1:0] r_hurt [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] r_hitb_p1;
  logic [NUM_PLAYERS-1:0] r_hurtb_p1;
  logic [NUM_PLAYERS-1:0] w_hitb;
  logic [NUM_PLAYERS-1:0] w_hurtb;

  // Latch the box geometry once per frame, alongside the positions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_hit[i]  <= '0;
        r_hurt[i] <= '0;
      end
    end else if (frame_tick) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_hit[i]  <= hit_box_flat[i*4*COORD_W +: 4*COORD_W];
        r_hurt[i] <= hurt_box_flat[i*4*COORD_W +: 4*COORD_W];
      end
    end
  end

  // Border hit tests for the pixel entering stage 1.
  always_comb begin
    w_hitb  = '0;
    w_hurtb = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      w_hitb[i]  = f_on_border(r_hit[i], pix_x, pix_y);
      w_hurtb[i] = f_on_border(r_hurt[i], pix_x, pix_y);
    end
  end

  // Stage 1 border flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hitb_p1  <= '0;
      r_hurtb_p1 <= '0;
    end else begin
      r_hitb_p1  <= w_hitb;
      r_hurtb_p1 <= w_hurtb;
    end
  end
`else
  logic w_unused_boxes;
  assign w_unused_boxes = ^{hit_box_flat, hurt_box_flat};
`endif

  // Latch position and state on frame_tick. This also marks the shadows valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_loaded <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_px[i] <= '0;
        r_py[i] <= '0;
        r_st[i] <= '0;
      end
    end else if (frame_tick) begin
      r_loaded <= 1'b1;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_px[i] <= posx_flat[i*COORD_W +: COORD_W];
        r_py[i] <= posy_flat[i*COORD_W +: COORD_W];
        r_st[i] <= state_flat[i*4 +: 4];
      end
    end
  end

  // Per-player flash counters. The active flag is registered from the next
  // count, so it always agrees with the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flash_active <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++)
        r_flash_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_flash_cnt[i]    <= f_flash_next(r_flash_cnt[i], hit_pulse[i], frame_tick);
        r_flash_active[i] <= (f_flash_next(r_flash_cnt[i], hit_pulse[i], frame_tick) != 8'd0);
      end
    end
  end

  assign flash_active = r_flash_active;

  // Body hit tests for the pixel entering stage 1.
  always_comb begin
    w_body = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      w_body[i] = f_in_body(r_px[i], r_py[i], pix_x, pix_y);
  end

  // Stage 1: hit flags, plus the state and flash snapshot this pixel uses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p1    <= 1'b0;
      r_loaded_p1 <= 1'b0;
      r_body_p1   <= '0;
      r_inv_p1    <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++)
        r_state_p1[i] <= '0;
    end else begin
      r_vld_p1    <= pix_valid;
      r_loaded_p1 <= r_loaded;
      r_body_p1   <= w_body;
      r_inv_p1    <= r_flash_active;
      for (int i = 0; i < NUM_PLAYERS; i++)
        r_state_p1[i] <= r_st[i];
    end
  end

  // Priority select. Layers are written from lowest to highest priority, and
  // each layer is scanned from the highest index down, so index 0 wins.
  always_comb begin
    w_color = BG_COLOR;
    for (int i = NUM_PLAYERS-1; i >= 0; i--)
      if (r_body_p1[i])
        w_color = r_inv_p1[i] ? ~f_body_color(r_state_p1[i]) : f_body_color(r_state_p1[i]);
`ifdef HITBOX_OVERLAY_EN
    for (int i = NUM_PLAYERS-1; i >= 0; i--)
      if (r_hurtb_p1[i])
        w_color = YELLOW;
    for (int i = NUM_PLAYERS-1; i >= 0; i--)
      if (r_hitb_p1[i] && ((r_state_p1[i] == 4'd4) || (r_state_p1[i] == 4'd5)))
        w_color = (r_state_p1[i] == 4'd4) ? RED : YELLOW;
`endif
    if (!r_loaded_p1)
      w_color = BG_COLOR;
  end

  // Stage 2: registered colour output. The colour holds while no pixel is valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      color_valid <= 1'b0;
      color_out   <= BG_COLOR;
    end else begin
      color_valid <= r_vld_p1;
      if (r_vld_p1)
        color_out <= w_color;
    end
  end

endmodule

// File: tb/tb_player_overlay_renderer.sv
// Testbench for player_overlay_renderer. It runs directed scenarios and then
// randomized traffic. Expected colours are pushed into a scoreboard when a
// pixel is issued, and a monitor pops and compares them when color_valid
// rises. The bench follows the HITBOX_OVERLAY_EN build macro.
module tb_player_overlay_renderer;
  localparam int NP = 2;
  localparam int W  = 10;
  localparam int FF = 3;
  localparam logic [7:0] BG = 8'b00100101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic pix_valid = 1'b0;
  logic [W-1:0] pix_x = '0, pix_y = '0;
  logic [NP*W-1:0] posx_flat = '0, posy_flat = '0;
  logic [NP*4-1:0] state_flat = '0;
  logic [NP*4*W-1:0] hit_box_flat = '0, hurt_box_flat = '0;
  logic [NP-1:0] hit_pulse = '0;
  logic [7:0] color_out;
  logic color_valid;
  logic [NP-1:0] flash_active;

  player_overlay_renderer #(.NUM_PLAYERS(NP), .COORD_W(W), .BOX_W(100), .BOX_H(100),
                            .FLASH_FRAMES(FF), .BG_COLOR(BG)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .posx_flat(posx_flat), .posy_flat(posy_flat),
    .state_flat(state_flat), .hit_box_flat(hit_box_flat), .hurt_box_flat(hurt_box_flat),
    .hit_pulse(hit_pulse), .color_out(color_out), .color_valid(color_valid),
    .flash_active(flash_active));

  always #10 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_chk = 0, n_pass = 0;

  // Driven player parameters, and the model's latched copy of them.
  int d_px[NP], d_py[NP], d_st[NP], d_hit[NP][4], d_hurt[NP][4];
  int m_px[NP], m_py[NP], m_st[NP], m_hit[NP][4], m_hurt[NP][4], m_flash[NP];
  bit m_loaded = 0;

  logic [7:0] q_col[$];
  int         q_cyc[$];
  logic [7:0] last_col = BG;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  function automatic logic [7:0] body_col(input int st);
    case (st)
      0: return 8'b11100000;
      1: return 8'b00001111;
      2: return 8'b11110000;
      3: return 8'b00011111;
      4: return 8'b11111100;
      default: return 8'b11111111;
    endcase
  endfunction

  function automatic bit on_rect(input int x1, x2, y1, y2, x, y);
    if (x1 > x2 || y1 > y2) return 0;
    return ((x == x1 || x == x2) && y >= y1 && y <= y2) ||
           ((y == y1 || y == y2) && x >= x1 && x <= x2);
  endfunction

  function automatic logic [7:0] exp_color(input int x, y);
    if (!m_loaded) return BG;
`ifdef HITBOX_OVERLAY_EN
    for (int i = 0; i < NP; i++)
      if ((m_st[i] == 4 || m_st[i] == 5) && on_rect(m_hit[i][0], m_hit[i][1], m_hit[i][2], m_hit[i][3], x, y))
        return (m_st[i] == 4) ? 8'b11100000 : 8'b11111100;
    for (int i = 0; i < NP; i++)
      if (on_rect(m_hurt[i][0], m_hurt[i][1], m_hurt[i][2], m_hurt[i][3], x, y))
        return 8'b11111100;
`endif
    for (int i = 0; i < NP; i++)
      if (x >= m_px[i] && x < m_px[i] + 100 && y >= m_py[i] && y < m_py[i] + 100)
        return (m_flash[i] != 0) ? ~body_col(m_st[i]) : body_col(m_st[i]);
    return BG;
  endfunction

  task automatic apply();
    for (int i = 0; i < NP; i++) begin
      posx_flat[i*W +: W]  = W'(d_px[i]);
      posy_flat[i*W +: W]  = W'(d_py[i]);
      state_flat[i*4 +: 4] = 4'(d_st[i]);
      for (int k = 0; k < 4; k++) begin
        hit_box_flat[i*4*W + (3-k)*W +: W]  = W'(d_hit[i][k]);
        hurt_box_flat[i*4*W + (3-k)*W +: W] = W'(d_hurt[i][k]);
      end
    end
  endtask

  task automatic set_player(input int i, x, y, st);
    d_px[i] = x; d_py[i] = y; d_st[i] = st;
    apply();
  endtask

  task automatic set_box(input int i, input bit hurt, input int x1, x2, y1, y2);
    if (hurt) begin d_hurt[i][0] = x1; d_hurt[i][1] = x2; d_hurt[i][2] = y1; d_hurt[i][3] = y2; end
    else      begin d_hit[i][0] = x1;  d_hit[i][1] = x2;  d_hit[i][2] = y1;  d_hit[i][3] = y2;  end
    apply();
  endtask

  task automatic model_reset();
    m_loaded = 0;
    for (int i = 0; i < NP; i++) begin
      m_px[i] = 0; m_py[i] = 0; m_st[i] = 0; m_flash[i] = 0;
      for (int k = 0; k < 4; k++) begin m_hit[i][k] = 0; m_hurt[i][k] = 0; end
    end
  endtask

  // Drive one cycle starting at posedge+1. The expectation uses pre-edge model state.
  task automatic step(input bit pv, input int x, y, input bit tick, input logic [NP-1:0] hp);
    pix_valid = pv; pix_x = W'(x); pix_y = W'(y); frame_tick = tick; hit_pulse = hp;
    if (pv) begin q_col.push_back(exp_color(x, y)); q_cyc.push_back(cyc_n); end
    @(posedge clk);
    if (tick) begin
      m_loaded = 1;
      m_px = d_px; m_py = d_py; m_st = d_st; m_hit = d_hit; m_hurt = d_hurt;
    end
    for (int i = 0; i < NP; i++)
      if (hp[i]) m_flash[i] = FF;
      else if (tick && m_flash[i] > 0) m_flash[i] = m_flash[i] - 1;
    #1;
    pix_valid = 0; frame_tick = 0; hit_pulse = '0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, '0);
  endtask

  task automatic rand_players();
    for (int i = 0; i < NP; i++) begin
      int bx, by;
      d_px[i] = $urandom_range(0, 1023); d_py[i] = $urandom_range(0, 1023);
      d_st[i] = $urandom_range(0, 7);
      bx = clamp(d_px[i] + $urandom_range(0, 99)); by = clamp(d_py[i] + $urandom_range(0, 99));
      d_hit[i][0] = bx; d_hit[i][1] = clamp(bx + $urandom_range(0, 30) - 5);
      d_hit[i][2] = by; d_hit[i][3] = clamp(by + $urandom_range(0, 30) - 5);
      bx = clamp(d_px[i] + $urandom_range(0, 99)); by = clamp(d_py[i] + $urandom_range(0, 99));
      d_hurt[i][0] = bx; d_hurt[i][1] = clamp(bx + $urandom_range(0, 40) - 5);
      d_hurt[i][2] = by; d_hurt[i][3] = clamp(by + $urandom_range(0, 40) - 5);
    end
    apply();
  endtask

  // Monitor: pop and compare on color_valid, check hold when idle, track flash flags.
  always @(negedge clk) begin
    if (rst) begin
      logic [NP-1:0] ef;
      if (color_valid) begin
        if (q_col.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          chk("color", color_out, q_col.pop_front());
          chk("latency", cyc_n - q_cyc.pop_front(), 2);
        end
        last_col = color_out;
      end else begin
        chk("hold", color_out, last_col);
      end
      for (int i = 0; i < NP; i++) ef[i] = (m_flash[i] != 0);
      chk("flash_active", flash_active, ef);
    end
  end

  initial begin
    model_reset();
    for (int i = 0; i < NP; i++) begin
      d_px[i] = 900; d_py[i] = 900; d_st[i] = 0;
      for (int k = 0; k < 4; k++) begin d_hit[i][k] = 0; d_hurt[i][k] = 0; end
      d_hit[i][0] = 5; d_hurt[i][0] = 5;
    end
    apply();
    #3 rst = 1'b0;
    #9;
    chk("rst_color", color_out, BG);
    chk("rst_valid", color_valid, 0);
    chk("rst_flash", flash_active, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Before any frame_tick, every pixel renders the background.
    step(1, 0, 0, 0, '0);
    idle(3);

    // Shadow latch, and immunity to input changes between ticks.
    set_player(0, 100, 200, 1);
    step(0, 0, 0, 1, '0);
    step(1, 150, 250, 0, '0);
    step(1, 200, 250, 0, '0);
    set_player(0, 300, 200, 1);
    step(1, 150, 250, 0, '0);
    step(1, 99, 250, 0, '0);
    idle(3);

    // Overlapping bodies: player 0 wins.
    set_player(0, 100, 100, 0);
    set_player(1, 100, 100, 2);
    step(0, 0, 0, 1, '0);
    step(1, 120, 120, 0, '0);
    step(1, 199, 199, 0, '0);
    step(1, 200, 150, 0, '0);
    idle(3);

    // Hit and hurt borders.
    set_player(0, 0, 0, 4);
    set_box(0, 0, 300, 310, 50, 60);
    step(0, 0, 0, 1, '0);
    step(1, 300, 55, 0, '0);
    step(1, 305, 60, 0, '0);
    set_player(0, 0, 0, 3);
    step(0, 0, 0, 1, '0);
    step(1, 300, 55, 0, '0);
    set_player(0, 0, 0, 5);
    set_box(1, 1, 20, 40, 20, 40);
    step(0, 0, 0, 1, '0);
    step(1, 310, 50, 0, '0);
    step(1, 20, 30, 0, '0);
    step(1, 30, 30, 0, '0);
    set_box(1, 1, 40, 20, 20, 40);
    step(0, 0, 0, 1, '0);
    step(1, 20, 30, 0, '0);
    idle(3);

    // Flash sequence, and reload on a coincident tick.
    set_player(0, 100, 100, 0);
    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 0, 2'b01);
    chk("flash_after_pulse", flash_active[0], 1);
    step(1, 120, 120, 0, '0);
    step(0, 0, 0, 1, '0); chk("flash_tick1", flash_active[0], 1);
    step(0, 0, 0, 1, '0); chk("flash_tick2", flash_active[0], 1);
    step(0, 0, 0, 1, '0); chk("flash_tick3", flash_active[0], 0);
    step(1, 120, 120, 0, '0);
    step(0, 0, 0, 0, 2'b01);
    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 1, 2'b01);
    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 1, '0); chk("flash_reload", flash_active[0], 1);
    step(0, 0, 0, 1, '0); chk("flash_reload_end", flash_active[0], 0);
    idle(3);

    // Randomized traffic.
    rand_players();
    step(0, 0, 0, 1, '0);
    for (int n = 0; n < 600; n++) begin
      int j, x, y, k;
      bit tick;
      logic [NP-1:0] hp;
      if ($urandom_range(0, 49) == 0) rand_players();
      tick = ($urandom_range(0, 24) == 0);
      hp = ($urandom_range(0, 39) == 0) ? NP'($urandom_range(1, 3)) : '0;
      j = $urandom_range(0, NP-1);
      k = $urandom_range(0, 3);
      case (k)
        0: begin x = $urandom_range(0, 1023); y = $urandom_range(0, 1023); end
        1: begin x = d_px[j] + $urandom_range(0, 120) - 10; y = d_py[j] + $urandom_range(0, 120) - 10; end
        2: begin x = d_hit[j][$urandom_range(0, 1)]; y = d_hit[j][2] + $urandom_range(0, 30) - 3; end
        default: begin x = d_hurt[j][0] + $urandom_range(0, 40) - 3; y = d_hurt[j][$urandom_range(2, 3)]; end
      endcase
      step($urandom_range(0, 3) != 0, clamp(x), clamp(y), tick, hp);
    end
    idle(3);

    // Reset with pixels in flight.
    set_player(0, 100, 100, 0);
    step(0, 0, 0, 1, '0);
    idle(3);
    pix_valid = 1; pix_x = 10'd120; pix_y = 10'd120;
    @(posedge clk); #1;
    pix_x = 10'd130;
    @(posedge clk); #1;
    rst = 1'b0; pix_valid = 0;
    model_reset();
    last_col = BG;
    #1;
    chk("midrst_valid", color_valid, 0);
    chk("midrst_color", color_out, BG);
    chk("midrst_flash", flash_active, 0);
    @(posedge clk); @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid0", color_valid, 0);
    idle(1);
    chk("post_rst_valid1", color_valid, 0);
    step(1, 120, 120, 0, '0);
    idle(2);
    step(0, 0, 0, 1, '0);
    step(1, 120, 120, 0, '0);
    idle(4);

    chk("scoreboard_empty", q_col.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
